// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: synchronizes an external reset request, then releases NUM_CH
// active-low reset channels one by one after a clean hold period.
// Ports:
//   CLK        - clock, rising edge
//   RST        - synchronous active-low block reset
//   EXT_RST_N  - asynchronous active-low external reset request
//   SW_RST     - synchronous active-high software reset request
//   SYNC_RST_N - sequenced active-low resets, bit 0 released first
//   DONE       - all channels released
//   STATE      - 00 ASSERT, 01 RELEASE, 10 DONE
//   EVT_CNT    - saturating count of aborts out of RELEASE/DONE
module rst_seq_ctrl #(
   parameter int unsigned NUM_STAGES  = 2,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned GAP_CYCLES  = 4,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EXT_RST_N,
   input  logic              SW_RST,
   output logic [NUM_CH-1:0] SYNC_RST_N,
   output logic              DONE,
   output logic [1:0]        STATE,
   output logic [7:0]        EVT_CNT
);

   localparam int unsigned KW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [KW-1:0]    LAST_CH   = KW'(NUM_CH - 1);

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'b00,
      ST_RELEASE = 2'b01,
      ST_DONE    = 2'b10
   } state_t;

   state_t              state_q;
   logic [NUM_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [KW-1:0]       k_q;
   logic [NUM_CH-1:0]   rst_n_q;
   logic                done_q;
   logic [7:0]          evt_q;
   logic                ext_sync_c;
   logic                abort_c;

   assign ext_sync_c = sync_q[NUM_STAGES-1];
   assign abort_c    = ~ext_sync_c | SW_RST;

   // Synchronizer, sequencing FSM and event counter; all outputs come from flops.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         sync_q  <= '0;
         state_q <= ST_ASSERT;
         cnt_q   <= '0;
         k_q     <= '0;
         rst_n_q <= '0;
         done_q  <= 1'b0;
         evt_q   <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], EXT_RST_N};
         case (state_q)
            ST_ASSERT: begin
               if (abort_c) begin
                  cnt_q <= '0;
               end else if (cnt_q == HOLD_LAST) begin
                  cnt_q   <= '0;
                  rst_n_q <= NUM_CH'(1);
                  if (NUM_CH == 1) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RELEASE;
                     k_q     <= KW'(1);
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               // Abort wins over a release falling on the same edge.
               if (abort_c) begin
                  state_q <= ST_ASSERT;
                  cnt_q   <= '0;
                  k_q     <= '0;
                  rst_n_q <= '0;
                  done_q  <= 1'b0;
                  if (evt_q != 8'hFF) evt_q <= evt_q + 8'd1;
               end else if (cnt_q == GAP_LAST) begin
                  cnt_q   <= '0;
                  rst_n_q <= rst_n_q | (NUM_CH'(1) << k_q);
                  k_q     <= k_q + KW'(1);
                  if (k_q == LAST_CH) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (abort_c) begin
                  state_q <= ST_ASSERT;
                  cnt_q   <= '0;
                  k_q     <= '0;
                  rst_n_q <= '0;
                  done_q  <= 1'b0;
                  if (evt_q != 8'hFF) evt_q <= evt_q + 8'd1;
               end
            end
            default: begin
               state_q <= ST_ASSERT;
               cnt_q   <= '0;
               k_q     <= '0;
               rst_n_q <= '0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign SYNC_RST_N = rst_n_q;
   assign DONE       = done_q;
   assign STATE      = state_q;
   assign EVT_CNT    = evt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed bench for rst_seq_ctrl at default parameters.
// Edges are counted from the first rising edge after RST deasserts (edge 1).
module tb_rst_seq_ctrl;

   logic       CLK;
   logic       RST;
   logic       EXT_RST_N;
   logic       SW_RST;
   logic [3:0] SYNC_RST_N;
   logic       DONE;
   logic [1:0] STATE;
   logic [7:0] EVT_CNT;

   int checks = 0;
   int errors = 0;

   rst_seq_ctrl dut (
      .CLK        (CLK),
      .RST        (RST),
      .EXT_RST_N  (EXT_RST_N),
      .SW_RST     (SW_RST),
      .SYNC_RST_N (SYNC_RST_N),
      .DONE       (DONE),
      .STATE      (STATE),
      .EVT_CNT    (EVT_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // One rising edge, then settle before sampling or driving.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Block reset for three edges; EXT_RST_N is high for edge 1 afterwards.
   task automatic do_reset();
      RST       = 1'b0;
      EXT_RST_N = 1'b1;
      SW_RST    = 1'b0;
      repeat (3) tick();
      RST = 1'b1;
   endtask

   // Expected fault-free power-up outputs at edge e.
   function automatic logic [3:0] exp_sync(input int e);
      logic [3:0] v;
      v = '0;
      for (int j = 0; j < 4; j++) if (e >= 18 + 4 * j) v[j] = 1'b1;
      return v;
   endfunction

   task automatic test_reset();
      logic [1:0] es;
      RST       = 1'b0;
      EXT_RST_N = 1'b0;
      SW_RST    = 1'b0;
      repeat (3) tick();
      checks++;
      if ({SYNC_RST_N, DONE, STATE, EVT_CNT} !== 15'd0) begin
         errors++;
         $display("FAIL reset_outputs: got sync=%b done=%b state=%b evt=%0d required all 0",
                  SYNC_RST_N, DONE, STATE, EVT_CNT);
      end
      EXT_RST_N = 1'b1;
      RST       = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         tick();
         es = (e < 18) ? 2'b00 : (e < 30) ? 2'b01 : 2'b10;
         checks++;
         if (SYNC_RST_N !== exp_sync(e)) begin
            errors++;
            $display("FAIL powerup_sync edge %0d: got %b required %b", e, SYNC_RST_N, exp_sync(e));
         end
         checks++;
         if (DONE !== (e >= 30)) begin
            errors++;
            $display("FAIL powerup_done edge %0d: got %b required %b", e, DONE, (e >= 30));
         end
         checks++;
         if (STATE !== es) begin
            errors++;
            $display("FAIL powerup_state edge %0d: got %b required %b", e, STATE, es);
         end
      end
      checks++;
      if (EVT_CNT !== 8'd0) begin
         errors++;
         $display("FAIL powerup_evt: got %0d required 0", EVT_CNT);
      end
   endtask

   task automatic test_glitch();
      do_reset();
      for (int e = 1; e <= 12; e++) tick();
      EXT_RST_N = 1'b0;
      tick();                       // edge 13 samples the glitch
      EXT_RST_N = 1'b1;
      for (int e = 14; e <= 43; e++) begin
         tick();
         if (e == 18 || e == 30) begin
            checks++;
            if (SYNC_RST_N !== 4'b0000) begin
               errors++;
               $display("FAIL glitch_hold edge %0d: got %b required 0000", e, SYNC_RST_N);
            end
         end
         if (e == 31) begin
            checks++;
            if (SYNC_RST_N !== 4'b0001 || STATE !== 2'b01) begin
               errors++;
               $display("FAIL glitch_release edge 31: got sync=%b state=%b required 0001/01",
                        SYNC_RST_N, STATE);
            end
         end
         if (e == 43) begin
            checks++;
            if (SYNC_RST_N !== 4'b1111 || DONE !== 1'b1) begin
               errors++;
               $display("FAIL glitch_done edge 43: got sync=%b done=%b required 1111/1",
                        SYNC_RST_N, DONE);
            end
         end
      end
      checks++;
      if (EVT_CNT !== 8'd0) begin
         errors++;
         $display("FAIL glitch_evt: got %0d required 0", EVT_CNT);
      end
   endtask

   task automatic test_mid_abort();
      do_reset();
      for (int e = 1; e <= 25; e++) tick();
      checks++;
      if (SYNC_RST_N !== 4'b0011) begin
         errors++;
         $display("FAIL mid_pre edge 25: got %b required 0011", SYNC_RST_N);
      end
      SW_RST = 1'b1;
      tick();                       // edge 26: channel 2 was due
      SW_RST = 1'b0;
      checks++;
      if (SYNC_RST_N !== 4'b0000 || STATE !== 2'b00 || DONE !== 1'b0) begin
         errors++;
         $display("FAIL mid_abort edge 26: got sync=%b state=%b done=%b required 0000/00/0",
                  SYNC_RST_N, STATE, DONE);
      end
      checks++;
      if (EVT_CNT !== 8'd1) begin
         errors++;
         $display("FAIL mid_abort_evt: got %0d required 1", EVT_CNT);
      end
      for (int e = 27; e <= 54; e++) begin
         tick();
         if (e == 41) begin
            checks++;
            if (SYNC_RST_N !== 4'b0000) begin
               errors++;
               $display("FAIL mid_rehold edge 41: got %b required 0000", SYNC_RST_N);
            end
         end
         if (e == 42) begin
            checks++;
            if (SYNC_RST_N !== 4'b0001) begin
               errors++;
               $display("FAIL mid_rerelease edge 42: got %b required 0001", SYNC_RST_N);
            end
         end
         if (e == 54) begin
            checks++;
            if (SYNC_RST_N !== 4'b1111 || DONE !== 1'b1 || STATE !== 2'b10) begin
               errors++;
               $display("FAIL mid_done edge 54: got sync=%b done=%b state=%b required 1111/1/10",
                        SYNC_RST_N, DONE, STATE);
            end
         end
      end
   endtask

   // Continues from DONE at edge 54 left by test_mid_abort.
   task automatic test_done_abort();
      EXT_RST_N = 1'b0;
      tick();                       // n = 55
      EXT_RST_N = 1'b1;
      tick();                       // n+1
      checks++;
      if (SYNC_RST_N !== 4'b1111 || DONE !== 1'b1) begin
         errors++;
         $display("FAIL done_abort_early edge 56: got sync=%b done=%b required 1111/1",
                  SYNC_RST_N, DONE);
      end
      tick();                       // n+2
      checks++;
      if (SYNC_RST_N !== 4'b0000 || DONE !== 1'b0 || STATE !== 2'b00) begin
         errors++;
         $display("FAIL done_abort edge 57: got sync=%b done=%b state=%b required 0000/0/00",
                  SYNC_RST_N, DONE, STATE);
      end
      checks++;
      if (EVT_CNT !== 8'd2) begin
         errors++;
         $display("FAIL done_abort_evt: got %0d required 2", EVT_CNT);
      end
   endtask

   task automatic test_saturation();
      int w;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         w = 0;
         while (DONE !== 1'b1 && w < 100) begin
            tick();
            w++;
         end
         if (DONE !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL sat_timeout abort %0d: DONE got %b required 1 within 100 edges", i, DONE);
            break;
         end
         SW_RST = 1'b1;
         tick();
         SW_RST = 1'b0;
         if (i == 253) begin
            checks++;
            if (EVT_CNT !== 8'd254) begin
               errors++;
               $display("FAIL sat_254: got %0d required 254", EVT_CNT);
            end
         end
         if (i == 254 || i == 299) begin
            checks++;
            if (EVT_CNT !== 8'd255 || STATE !== 2'b00) begin
               errors++;
               $display("FAIL sat_255 abort %0d: got evt=%0d state=%b required 255/00",
                        i + 1, EVT_CNT, STATE);
            end
         end
      end
   endtask

   task automatic test_rst_mid_release();
      int w;
      w = 0;
      while (SYNC_RST_N !== 4'b0011 && w < 100) begin
         tick();
         w++;
      end
      checks++;
      if (SYNC_RST_N !== 4'b0011) begin
         errors++;
         $display("FAIL rst_mid_reach: got %b required 0011 within 100 edges", SYNC_RST_N);
      end
      RST = 1'b0;
      tick();
      checks++;
      if ({SYNC_RST_N, DONE, STATE, EVT_CNT} !== 15'd0) begin
         errors++;
         $display("FAIL rst_mid_clear: got sync=%b done=%b state=%b evt=%0d required all 0",
                  SYNC_RST_N, DONE, STATE, EVT_CNT);
      end
      RST = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         tick();
         if (e == 17 || e == 18 || e == 26) begin
            checks++;
            if (SYNC_RST_N !== exp_sync(e)) begin
               errors++;
               $display("FAIL rst_restart edge %0d: got %b required %b", e, SYNC_RST_N, exp_sync(e));
            end
         end
      end
      checks++;
      if (SYNC_RST_N !== 4'b1111 || DONE !== 1'b1 || STATE !== 2'b10 || EVT_CNT !== 8'd0) begin
         errors++;
         $display("FAIL rst_restart_done edge 30: got sync=%b done=%b state=%b evt=%0d required 1111/1/10/0",
                  SYNC_RST_N, DONE, STATE, EVT_CNT);
      end
   endtask

   initial begin
      RST       = 1'b0;
      EXT_RST_N = 1'b0;
      SW_RST    = 1'b0;
      test_reset();
      test_glitch();
      test_mid_abort();
      test_done_abort();
      test_saturation();
      test_rst_mid_release();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
